// File: rtl/halflife_decay.sv
// halflife_decay: repeatedly halves a latched amount every period cycles until it reaches zero.
module halflife_decay #(
    parameter int W  = 8,
    parameter int PW = 8,
    parameter int HW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  amount_in,
    input  logic [PW-1:0] period_in,
    output logic [W-1:0]  amount_out,
    output logic [HW-1:0] halvings,
    output logic          busy,
    output logic          tick,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [PW-1:0] period, period_n, timer, timer_n;
    logic [W-1:0] amount_n, half;
    logic [HW-1:0] halv_n, halv_inc;
    logic tick_n, last;
    assign half     = amount_out >> 1;
    assign last     = timer == period - PW'(1);
    assign halv_inc = &halvings ? halvings : halvings + HW'(1);
    always_comb begin
        state_n  = state;
        period_n = period;
        timer_n  = timer;
        amount_n = amount_out;
        halv_n   = halvings;
        tick_n   = 1'b0;
        case (state)
            IDLE: if (start) begin
                amount_n = amount_in;
                period_n = period_in == '0 ? PW'(1) : period_in;
                timer_n  = '0;
                halv_n   = '0;
                state_n  = amount_in == '0 ? DONE : RUN;
            end
            RUN: if (abort) state_n = IDLE;
            else if (last) begin
                amount_n = half;
                halv_n   = halv_inc;
                timer_n  = '0;
                tick_n   = 1'b1;
                state_n  = half == '0 ? DONE : RUN;
            end else timer_n = timer + PW'(1);
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            period     <= PW'(1);
            timer      <= '0;
            amount_out <= '0;
            halvings   <= '0;
            tick       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            period     <= period_n;
            timer      <= timer_n;
            amount_out <= amount_n;
            halvings   <= halv_n;
            tick       <= tick_n;
            busy       <= state_n == RUN;
            done       <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_halflife_decay.sv
// tb_halflife_decay: directed and randomized checks against an elapsed-time model of the decay.
module tb_halflife_decay;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [7:0] amount_in = '0, period_in = '0, amount_out;
    logic [3:0] halvings;
    logic busy, tick, done;
    int tests = 0, fails = 0;
    int m_a = 0, m_p = 1, m_z = 0, m_e = 100000, m_hab = 0;
    bit m_ab = 1'b0;

    halflife_decay dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .amount_in(amount_in), .period_in(period_in),
        .amount_out(amount_out), .halvings(halvings),
        .busy(busy), .tick(tick), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic int nbits(input int v);
        int n = 0;
        while (v != 0) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    // The model tracks only edges elapsed since the accepted start; all outputs follow from that.
    function automatic bit m_idle();
        return m_ab || m_e > m_z * m_p;
    endfunction

    function automatic bit m_busy();
        return !m_ab && (m_e / m_p < m_z);
    endfunction

    task automatic m_reset();
        m_a = 0; m_p = 1; m_z = 0; m_e = 100000; m_ab = 1'b0; m_hab = 0;
    endtask

    task automatic check_all(input string tag);
        int h;
        h = m_ab ? m_hab : (m_e / m_p < m_z ? m_e / m_p : m_z);
        chk({tag, "_amount"}, int'(amount_out), m_a >> h);
        chk({tag, "_halvings"}, int'(halvings), h);
        chk({tag, "_busy"}, int'(busy), int'(m_busy()));
        chk({tag, "_done"}, int'(done), int'(!m_ab && m_e == m_z * m_p));
        chk({tag, "_tick"}, int'(tick), int'(!m_ab && m_e > 0 && m_e % m_p == 0 && m_e / m_p <= m_z));
    endtask

    task automatic cyc(input string tag);
        if (m_idle() && start) begin
            m_a = int'(amount_in);
            m_p = period_in == 0 ? 1 : int'(period_in);
            m_z = nbits(m_a);
            m_e = 0;
            m_ab = 1'b0;
        end else if (m_busy() && abort) begin
            m_ab = 1'b1;
            m_hab = m_e / m_p;
        end else if (m_e < 100000) m_e++;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic launch(input int a, input int p);
        amount_in = 8'(a);
        period_in = 8'(p);
        start = 1'b1;
        cyc("start");
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check_all("rst");
        #16 rst = 1'b1;
        launch(8, 3);
        for (int i = 1; i <= 13; i++) begin
            cyc("s1");
            chk("s1_amount_c", int'(amount_out), 8 >> (i < 12 ? i / 3 : 4));
            if (i % 3 == 0) chk("s1_tick_c", int'(tick), 1);
            if (i == 12) begin
                chk("s1_done_c", int'(done), 1);
                chk("s1_halv_c", int'(halvings), 4);
            end
            if (i == 13) chk("s1_idle_c", int'(done | busy), 0);
        end
        launch(0, 5);
        chk("s2_done_c", int'(done), 1);
        chk("s2_busy_c", int'(busy), 0);
        cyc("s2");
        launch(255, 0);
        for (int i = 1; i <= 8; i++) cyc("s3");
        chk("s3_halv_c", int'(halvings), 8);
        chk("s3_done_c", int'(done), 1);
        cyc("s3");
        launch(200, 4);
        for (int i = 1; i <= 8; i++) begin
            start = i == 2;
            amount_in = 8'd7;
            abort = i == 6;
            cyc("s4");
        end
        chk("s4_amount_c", int'(amount_out), 100);
        chk("s4_halv_c", int'(halvings), 1);
        launch(100, 3);
        for (int i = 0; i < 5; i++) cyc("s5");
        #3 rst = 1'b0;
        #1 m_reset();
        check_all("arst");
        @(posedge clk);
        #1 check_all("arst_hold");
        #2 rst = 1'b1;
        launch(6, 2);
        for (int i = 1; i <= 7; i++) cyc("s6");
        chk("s6_halv_c", int'(halvings), 3);
        chk("s6_amount_c", int'(amount_out), 0);
        for (int r = 0; r < 40; r++) begin
            launch($urandom_range(0, 255), $urandom_range(0, 6));
            for (int i = 0; i < 100 && !m_idle(); i++) begin
                start = $urandom_range(0, 4) == 0;
                amount_in = 8'($urandom_range(0, 255));
                abort = $urandom_range(0, 30) == 0;
                cyc("rnd");
            end
            start = 1'b0;
            abort = 1'b0;
            for (int i = 0; i < 2; i++) cyc("rnd_idle");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/halflife_decay.md
HALFLIFE_DECAY -- requirements
Module: halflife_decay

Interface
REQ-001 Parameter W, default 8, bit width of the amount path.
REQ-002 Parameter PW, default 8, bit width of the half-life period.
REQ-003 Parameter HW, default 4, bit width of the halvings counter.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to begin a decay run; sampled only in IDLE.
REQ-007 abort  input  1  cancels a run in progress; sampled only in RUN.
REQ-008 amount_in  input  W  initial quantity, latched on accepted start.
REQ-009 period_in  input  PW  half-life in clock cycles, latched on accepted start.
REQ-010 amount_out  output  W  current remaining quantity (registered).
REQ-011 halvings  output  HW  number of half-lives elapsed in the current or last run (registered).
REQ-012 busy  output  1  high while in RUN.
REQ-013 tick  output  1  one-cycle pulse, high in the cycle after each halving.
REQ-014 done  output  1  one-cycle pulse, high for the single cycle the FSM spends in DONE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE with start=1 at an edge, the block SHALL do all of the following:
- latch amount_in into amount_out;
- latch period_in into the period register, with 0 replaced by 1;
- clear halvings and the cycle timer;
- go to RUN, or go directly to DONE if amount_in==0.
REQ-017 In RUN, the timer SHALL increment every cycle.
REQ-018 When the timer equals period-1 at an edge, the block SHALL do all of the following at that edge:
- amount_out <= amount_out>>1 (logical shift; odd amounts truncate);
- halvings <= halvings+1, saturating at 2^HW-1;
- timer <= 0;
- tick <= 1.
REQ-019 The first halving SHALL occur exactly P edges after the start-accept edge, and each later halving P edges after the previous one.
REQ-020 If a halving produces amount 0, the FSM SHALL enter DONE at that same edge.
REQ-021 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE); both are registered.
REQ-022 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-023 start in RUN or DONE SHALL be ignored.
REQ-024 abort=1 in RUN SHALL return the FSM to IDLE at the next edge with no done pulse.
- amount_out and halvings hold their values.
- An abort coinciding with a halving edge takes priority: no halving and no tick.
REQ-025 amount_out and halvings SHALL hold their values in IDLE and DONE until the next accepted start.
REQ-026 tick SHALL be low in every cycle not immediately following a halving.

Reset
REQ-027 While rst=0, the block SHALL asynchronously force:
- state=IDLE;
- amount_out=0, halvings=0;
- timer=0, period register=1;
- busy=0, tick=0, done=0.
REQ-028 Reset asserted mid-run SHALL abandon the run, and no done pulse SHALL follow reset release.
REQ-029 After release, the first start SHALL be accepted at the first rising edge with rst=1.

Verification
REQ-030 Scenario: amount_in=8, period_in=3, start accepted at edge k.
- amount_out SHALL go 8->4->2->1->0 at edges k+3, k+6, k+9, k+12.
- tick SHALL be high in the cycles after each of those edges.
- done SHALL be high and busy low in the cycle after edge k+12, with halvings=4.
- The FSM SHALL be in IDLE after edge k+13.
REQ-031 Scenario: amount_in=0, period_in=5, start.
- done SHALL pulse in the next cycle with halvings=0 and busy never high.
REQ-032 Scenario: amount_in=255, period_in=0.
- One halving SHALL occur per cycle: 127, 63, ..., 0 over 8 edges, then halvings=8 and done.
REQ-033 Scenario: amount_in=200, period_in=4, abort asserted at edge k+6.
- The FSM SHALL be in IDLE with amount_out=100 and halvings=1, and done SHALL never assert.
- start pulsed at edge k+2 SHALL have no effect.
REQ-034 Scenario: rst driven low mid-run, asynchronously between edges.
- All outputs SHALL go to 0 immediately.
- After release, amount_in=6, period_in=2 SHALL give 6->3->1->0 with halvings=3.
